// File: rtl/rename_register_file_pkg.sv
// Shared constants and default widths for the rename register file slice.
package rename_register_file_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_REG_NUM   = 32;
    localparam int unsigned DEF_ROB_ID_W  = 4;
    localparam int unsigned DEF_RD_PORTS  = 2;
    localparam int unsigned DEF_CMT_PORTS = 2;

    // Register index 0 is x0; ROB id 0 means "value ready, no pending producer".
    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned ZERO_ROB  = 0;
    localparam int unsigned ZERO_WORD = 0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rename_register_file_rf_read_port.sv
// One source-operand read port: commit-priority bypass in front of the stored V/Q.
module rename_register_file_rf_read_port
    import rename_register_file_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned ROB_ID_W  = DEF_ROB_ID_W,
    parameter int unsigned CMT_PORTS = DEF_CMT_PORTS
) (
    input  logic [REG_W-1:0]              i_rs,
    input  logic [DATA_W-1:0]             i_reg_v,
    input  logic [ROB_ID_W-1:0]           i_reg_q,
    input  logic [CMT_PORTS-1:0]          i_cmt_vld,
    input  logic [CMT_PORTS*REG_W-1:0]    i_cmt_rd,
    input  logic [CMT_PORTS*ROB_ID_W-1:0] i_cmt_q,
    input  logic [CMT_PORTS*DATA_W-1:0]   i_cmt_v,
    input  logic                          i_flush,
    output logic [DATA_W-1:0]             o_v_c,
    output logic [ROB_ID_W-1:0]           o_q_c
);

    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_v;
    logic [ROB_ID_W-1:0] w_hit_q;
    logic                w_rs_zero;

    // Later ports are younger, so a later match overrides an earlier one.
    always_comb begin
        w_hit   = FALSE;
        w_hit_v = DATA_W'(ZERO_WORD);
        w_hit_q = ROB_ID_W'(ZERO_ROB);
        for (int unsigned k = 0; k < CMT_PORTS; k++) begin
            if (i_cmt_vld[k] && (i_cmt_rd[k*REG_W +: REG_W] == i_rs)) begin
                w_hit   = TRUE;
                w_hit_v = i_cmt_v[k*DATA_W +: DATA_W];
                w_hit_q = i_cmt_q[k*ROB_ID_W +: ROB_ID_W];
            end
        end
    end

    assign w_rs_zero = (i_rs == REG_W'(ZERO_REG));

    // x0 reads zero; a tag only clears when the youngest commit is its producer.
    always_comb begin
        o_v_c = i_reg_v;
        o_q_c = i_reg_q;
        if (w_rs_zero) begin
            o_v_c = DATA_W'(ZERO_WORD);
        end else if (w_hit) begin
            o_v_c = w_hit_v;
        end
        if (i_flush || w_rs_zero || (w_hit && (w_hit_q == i_reg_q))) begin
            o_q_c = ROB_ID_W'(ZERO_ROB);
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags and a live busy counter.
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_NUM   = DEF_REG_NUM,
    parameter int unsigned ROB_ID_W  = DEF_ROB_ID_W,
    parameter int unsigned RD_PORTS  = DEF_RD_PORTS,
    parameter int unsigned CMT_PORTS = DEF_CMT_PORTS,
    localparam int unsigned REG_W    = $clog2(REG_NUM),
    localparam int unsigned CNT_W    = $clog2(REG_NUM + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [RD_PORTS*REG_W-1:0]     rs_i,
    output logic [RD_PORTS*DATA_W-1:0]    v_o,
    output logic [RD_PORTS*ROB_ID_W-1:0]  q_o,
    input  logic                          alloc_i,
    input  logic [REG_W-1:0]              alloc_rd_i,
    input  logic [ROB_ID_W-1:0]           alloc_q_i,
    input  logic [CMT_PORTS-1:0]          cmt_vld_i,
    input  logic [CMT_PORTS*REG_W-1:0]    cmt_rd_i,
    input  logic [CMT_PORTS*ROB_ID_W-1:0] cmt_q_i,
    input  logic [CMT_PORTS*DATA_W-1:0]   cmt_v_i,
    input  logic                          flush_i,
    output logic [CNT_W-1:0]              busy_cnt_o
);

    logic [DATA_W-1:0]   r_v [REG_NUM];
    logic [ROB_ID_W-1:0] r_q [REG_NUM];
    logic [CNT_W-1:0]    r_busy;

    logic [DATA_W-1:0]   w_v_nxt [REG_NUM];
    logic [ROB_ID_W-1:0] w_q_nxt [REG_NUM];
    logic [REG_NUM-1:0]  w_clr;
    logic [CNT_W-1:0]    w_dec;
    logic                w_inc;
    logic [CNT_W-1:0]    w_busy_nxt;
    logic [CNT_W-1:0]    w_pop;
    logic [REG_W-1:0]    w_rs [RD_PORTS];

    // One bypass mux per source operand.
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign w_rs[p] = rs_i[p*REG_W +: REG_W];

        rename_register_file_rf_read_port #(
            .DATA_W    (DATA_W),
            .REG_W     (REG_W),
            .ROB_ID_W  (ROB_ID_W),
            .CMT_PORTS (CMT_PORTS)
        ) u_rd_port (
            .i_rs      (w_rs[p]),
            .i_reg_v   (r_v[w_rs[p]]),
            .i_reg_q   (r_q[w_rs[p]]),
            .i_cmt_vld (cmt_vld_i),
            .i_cmt_rd  (cmt_rd_i),
            .i_cmt_q   (cmt_q_i),
            .i_cmt_v   (cmt_v_i),
            .i_flush   (flush_i),
            .o_v_c     (v_o[p*DATA_W +: DATA_W]),
            .o_q_c     (q_o[p*ROB_ID_W +: ROB_ID_W])
        );
    end

    // Next state: commits (younger port last), tag clears against pre-edge Q, then flush or alloc.
    always_comb begin
        w_v_nxt    = r_v;
        w_q_nxt    = r_q;
        w_clr      = '0;
        w_dec      = '0;
        w_inc      = FALSE;
        w_busy_nxt = r_busy;
        for (int unsigned k = 0; k < CMT_PORTS; k++) begin
            if (cmt_vld_i[k] && (cmt_rd_i[k*REG_W +: REG_W] != REG_W'(ZERO_REG))) begin
                w_v_nxt[cmt_rd_i[k*REG_W +: REG_W]] = cmt_v_i[k*DATA_W +: DATA_W];
                if ((r_q[cmt_rd_i[k*REG_W +: REG_W]] != ROB_ID_W'(ZERO_ROB)) &&
                    (r_q[cmt_rd_i[k*REG_W +: REG_W]] == cmt_q_i[k*ROB_ID_W +: ROB_ID_W])) begin
                    w_clr[cmt_rd_i[k*REG_W +: REG_W]] = TRUE;
                end
            end
        end
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (w_clr[r]) begin
                w_q_nxt[r] = ROB_ID_W'(ZERO_ROB);
                w_dec      = w_dec + CNT_W'(1);
            end
        end
        if (flush_i) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                w_q_nxt[r] = ROB_ID_W'(ZERO_ROB);
            end
            w_busy_nxt = '0;
        end else begin
            if (alloc_i && (alloc_rd_i != REG_W'(ZERO_REG))) begin
                w_q_nxt[alloc_rd_i] = alloc_q_i;
                w_inc = (r_q[alloc_rd_i] == ROB_ID_W'(ZERO_ROB)) || w_clr[alloc_rd_i];
            end
            w_busy_nxt = r_busy - w_dec + CNT_W'(w_inc);
        end
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                r_v[r] <= '0;
                r_q[r] <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            r_v    <= w_v_nxt;
            r_q    <= w_q_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_cnt_o = r_busy;

    // Reference popcount of the tag table for the incremental counter check.
    always_comb begin
        w_pop = '0;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            if (r_q[r] != ROB_ID_W'(ZERO_ROB)) begin
                w_pop = w_pop + CNT_W'(1);
            end
        end
    end

    property p_busy_matches_pop;
        @(posedge clk) disable iff (!rst) (r_busy == w_pop) && (r_q[0] == ROB_ID_W'(ZERO_ROB));
    endproperty
    a_busy_matches_pop: assert property (p_busy_matches_pop);

endmodule

// File: tb/tb_rename_register_file.sv
// Scoreboard bench for rename_register_file: model predicts reads/busy, queue holds expectations.
module tb_rename_register_file;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned ROB_ID_W  = 4;
    localparam int unsigned RD_PORTS  = 2;
    localparam int unsigned CMT_PORTS = 2;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W     = 6;

    logic                          clk;
    logic                          rst;
    logic                          rdy;
    logic [RD_PORTS*REG_W-1:0]     rs_i;
    logic [RD_PORTS*DATA_W-1:0]    v_o;
    logic [RD_PORTS*ROB_ID_W-1:0]  q_o;
    logic                          alloc_i;
    logic [REG_W-1:0]              alloc_rd_i;
    logic [ROB_ID_W-1:0]           alloc_q_i;
    logic [CMT_PORTS-1:0]          cmt_vld_i;
    logic [CMT_PORTS*REG_W-1:0]    cmt_rd_i;
    logic [CMT_PORTS*ROB_ID_W-1:0] cmt_q_i;
    logic [CMT_PORTS*DATA_W-1:0]   cmt_v_i;
    logic                          flush_i;
    logic [CNT_W-1:0]              busy_cnt_o;

    rename_register_file #(
        .DATA_W    (DATA_W),
        .REG_NUM   (REG_NUM),
        .ROB_ID_W  (ROB_ID_W),
        .RD_PORTS  (RD_PORTS),
        .CMT_PORTS (CMT_PORTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rs_i       (rs_i),
        .v_o        (v_o),
        .q_o        (q_o),
        .alloc_i    (alloc_i),
        .alloc_rd_i (alloc_rd_i),
        .alloc_q_i  (alloc_q_i),
        .cmt_vld_i  (cmt_vld_i),
        .cmt_rd_i   (cmt_rd_i),
        .cmt_q_i    (cmt_q_i),
        .cmt_v_i    (cmt_v_i),
        .flush_i    (flush_i),
        .busy_cnt_o (busy_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_q [$];
    string       tag_q [$];

    logic [DATA_W-1:0]   m_v [REG_NUM];
    logic [ROB_ID_W-1:0] m_q [REG_NUM];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int model_busy();
        int c = 0;
        for (int r = 0; r < int'(REG_NUM); r++) if (m_q[r] != '0) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < int'(REG_NUM); r++) begin
            m_v[r] = '0;
            m_q[r] = '0;
        end
    endtask

    // Predict combinational reads and current busy count; push to scoreboard.
    task automatic push_expect();
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            logic [REG_W-1:0]    rs;
            logic                hit;
            logic [DATA_W-1:0]   hv;
            logic [ROB_ID_W-1:0] hq;
            logic [DATA_W-1:0]   ev;
            logic [ROB_ID_W-1:0] eq;
            rs  = rs_i[p*REG_W +: REG_W];
            hit = 1'b0;
            hv  = '0;
            hq  = '0;
            for (int k = 0; k < int'(CMT_PORTS); k++) begin
                if (cmt_vld_i[k] && cmt_rd_i[k*REG_W +: REG_W] == rs) begin
                    hit = 1'b1;
                    hv  = cmt_v_i[k*DATA_W +: DATA_W];
                    hq  = cmt_q_i[k*ROB_ID_W +: ROB_ID_W];
                end
            end
            if (rs == '0) ev = '0;
            else if (hit) ev = hv;
            else ev = m_v[rs];
            if (flush_i || rs == '0) eq = '0;
            else if (hit && hq == m_q[rs]) eq = '0;
            else eq = m_q[rs];
            exp_q.push_back(64'(ev));
            tag_q.push_back($sformatf("v%0d(x%0d)", p, rs));
            exp_q.push_back(64'(eq));
            tag_q.push_back($sformatf("q%0d(x%0d)", p, rs));
        end
        exp_q.push_back(64'(model_busy()));
        tag_q.push_back("busy");
    endtask

    task automatic pop_compare();
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            chk(tag_q.pop_front(), 64'(v_o[p*DATA_W +: DATA_W]), exp_q.pop_front());
            chk(tag_q.pop_front(), 64'(q_o[p*ROB_ID_W +: ROB_ID_W]), exp_q.pop_front());
        end
        chk(tag_q.pop_front(), 64'(busy_cnt_o), exp_q.pop_front());
    endtask

    // Model of the clock edge: commits, tag clears, then flush or allocate.
    task automatic model_edge();
        logic [REG_NUM-1:0] clr;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        clr = '0;
        for (int k = 0; k < int'(CMT_PORTS); k++) begin
            logic [REG_W-1:0] rd;
            rd = cmt_rd_i[k*REG_W +: REG_W];
            if (cmt_vld_i[k] && rd != '0) begin
                if (m_q[rd] != '0 && m_q[rd] == cmt_q_i[k*ROB_ID_W +: ROB_ID_W]) clr[rd] = 1'b1;
            end
        end
        for (int k = 0; k < int'(CMT_PORTS); k++) begin
            logic [REG_W-1:0] rd;
            rd = cmt_rd_i[k*REG_W +: REG_W];
            if (cmt_vld_i[k] && rd != '0) m_v[rd] = cmt_v_i[k*DATA_W +: DATA_W];
        end
        for (int r = 0; r < int'(REG_NUM); r++) if (clr[r]) m_q[r] = '0;
        if (flush_i) begin
            for (int r = 0; r < int'(REG_NUM); r++) m_q[r] = '0;
        end else if (alloc_i && alloc_rd_i != '0) begin
            m_q[alloc_rd_i] = alloc_q_i;
        end
    endtask

    task automatic step();
        push_expect();
        @(negedge clk);
        pop_compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int r0, input int r1);
        rdy       = 1'b1;
        alloc_i   = 1'b0;
        alloc_rd_i = '0;
        alloc_q_i = '0;
        cmt_vld_i = '0;
        cmt_rd_i  = '0;
        cmt_q_i   = '0;
        cmt_v_i   = '0;
        flush_i   = 1'b0;
        rs_i      = {REG_W'(r1), REG_W'(r0)};
    endtask

    task automatic set_alloc(input int rd, input int q);
        alloc_i    = 1'b1;
        alloc_rd_i = REG_W'(rd);
        alloc_q_i  = ROB_ID_W'(q);
    endtask

    task automatic set_cmt(input int k, input int rd, input int q, input logic [DATA_W-1:0] v);
        cmt_vld_i[k] = 1'b1;
        cmt_rd_i[k*REG_W +: REG_W]       = REG_W'(rd);
        cmt_q_i[k*ROB_ID_W +: ROB_ID_W]  = ROB_ID_W'(q);
        cmt_v_i[k*DATA_W +: DATA_W]      = v;
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        idle(5, 0);
        step();
        rst = 1'b1;

        // Reset mid-traffic takes effect without a clock edge.
        idle(5, 0); set_alloc(5, 3); step();
        idle(5, 0); step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_q5", 64'(q_o[ROB_ID_W-1:0]), 64'd0);
        chk("rst_v5", 64'(v_o[DATA_W-1:0]), 64'd0);
        chk("rst_busy", 64'(busy_cnt_o), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Alloc then matching commit with same-cycle bypass.
        idle(5, 1); set_alloc(5, 3); step();
        idle(5, 5); set_cmt(0, 5, 3, 32'hAB); step();
        idle(5, 0); step();

        // Stale commit writes V but leaves the newer tag.
        idle(5, 0); set_alloc(5, 3); step();
        idle(5, 0); set_alloc(5, 7); step();
        idle(5, 0); set_cmt(0, 5, 3, 32'h1); step();
        idle(5, 0); step();

        // Two ports commit the same register: younger value wins.
        idle(6, 0); set_alloc(6, 4); step();
        idle(6, 5); set_cmt(0, 6, 2, 32'd10); set_cmt(1, 6, 4, 32'd20); step();
        idle(6, 5); step();

        // Same-cycle allocate overrides commit clear.
        idle(7, 0); set_alloc(7, 5); step();
        idle(7, 6); set_alloc(7, 9); set_cmt(0, 7, 5, 32'h77); step();
        idle(7, 5); step();

        // Flush drops all tags and ignores allocation.
        idle(9, 10); set_alloc(9, 1); step();
        idle(9, 10); set_alloc(10, 2); step();
        idle(11, 8); set_alloc(11, 3); step();
        idle(8, 9); flush_i = 1'b1; set_alloc(8, 1); step();
        idle(8, 5); step();

        // rdy low: nothing changes, bypass still visible.
        idle(12, 0); set_alloc(12, 6); step();
        idle(12, 13); rdy = 1'b0; set_alloc(13, 2); set_cmt(0, 12, 6, 32'h55); step();
        idle(12, 13); step();

        // x0 writes are discarded.
        idle(0, 12); set_alloc(0, 5); set_cmt(1, 0, 0, 32'hDEAD); step();
        idle(0, 12); step();

        // Random traffic; commit tags usually match the producer.
        for (int n = 0; n < 400; n++) begin
            idle($urandom_range(0, 31), $urandom_range(0, 31));
            rdy     = ($urandom_range(0, 9) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) set_alloc($urandom_range(0, 31), $urandom_range(1, 15));
            for (int k = 0; k < int'(CMT_PORTS); k++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int rd;
                    int q;
                    rd = $urandom_range(0, 15);
                    q  = ($urandom_range(0, 3) != 0) ? int'(m_q[rd]) : int'($urandom_range(0, 15));
                    set_cmt(k, rd, q, $urandom());
                end
            end
            step();
        end

        if (exp_q.size() != 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
